// File: rtl/interface_ov7670_uc_if.sv
// interface_ov7670_uc_if: control/status bundle between the OV7670 capture control unit and its datapath
interface interface_ov7670_uc_if;
  logic       iniciar;
  logic       href;
  logic       transmite_frame;
  logic       transmite_byte;
  logic       escreve_byte;
  logic       fim_coluna_pixel;
  logic       fim_linha_pixel;
  logic       fim_coluna_quadrante;
  logic       byte_estavel;
  logic       we_byte;
  logic       zera_linha_pixel;
  logic       zera_coluna_pixel;
  logic       zera_linha_quadrante;
  logic       zera_coluna_quadrante;
  logic       conta_linha_pixel;
  logic       conta_coluna_pixel;
  logic       conta_linha_quadrante;
  logic       conta_coluna_quadrante;
  logic       pronto;
  logic       erro;
  logic [3:0] db_estado;
  modport master (
    output iniciar, href, transmite_frame, transmite_byte, escreve_byte,
           fim_coluna_pixel, fim_linha_pixel, fim_coluna_quadrante,
    input  byte_estavel, we_byte, zera_linha_pixel, zera_coluna_pixel,
           zera_linha_quadrante, zera_coluna_quadrante, conta_linha_pixel,
           conta_coluna_pixel, conta_linha_quadrante, conta_coluna_quadrante,
           pronto, erro, db_estado
  );
  modport slave (
    input  iniciar, href, transmite_frame, transmite_byte, escreve_byte,
           fim_coluna_pixel, fim_linha_pixel, fim_coluna_quadrante,
    output byte_estavel, we_byte, zera_linha_pixel, zera_coluna_pixel,
           zera_linha_quadrante, zera_coluna_quadrante, conta_linha_pixel,
           conta_coluna_pixel, conta_linha_quadrante, conta_coluna_quadrante,
           pronto, erro, db_estado
  );
endinterface

// File: rtl/interface_ov7670_uc.sv
// interface_ov7670_uc: sequences OV7670 capture, assembling 16-bit pixels and storing N_AMOSTRAS sample points
module interface_ov7670_uc #(
  parameter int N_AMOSTRAS = 9,
  parameter int S_AMOSTRAS = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  interface_ov7670_uc_if.slave bus
);
  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARA       = 4'h1,
    ESPERA_FRAME  = 4'h2,
    ESPERA_BYTE1  = 4'h3,
    CAPTURA_BYTE1 = 4'h4,
    ESPERA_BYTE2  = 4'h5,
    CAPTURA_BYTE2 = 4'h6,
    AVALIA        = 4'h7,
    ARMAZENA      = 4'h8,
    ATUALIZA_QUAD = 4'h9,
    CONTA_PIXEL   = 4'hA,
    FIM           = 4'hB,
    FIM_ERRO      = 4'hC
  } state_t;
  localparam logic [S_AMOSTRAS-1:0] N = S_AMOSTRAS'(N_AMOSTRAS);
  state_t                state_q, state_d;
  logic [S_AMOSTRAS-1:0] count_q, count_d;
  logic                  erro_q, erro_d;
  logic                  byte_ok, restart;
  assign byte_ok = bus.transmite_byte & bus.href;
  // a new frame mid-capture discards the partial capture and starts over
  assign restart = bus.transmite_frame && state_q >= ESPERA_BYTE1 && state_q <= CONTA_PIXEL;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= INICIAL;
      count_q <= '0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      erro_q  <= erro_d;
    end
  always_comb begin
    state_d                    = state_q;
    count_d                    = count_q;
    bus.byte_estavel           = 1'b0;
    bus.we_byte                = 1'b0;
    bus.zera_linha_pixel       = 1'b0;
    bus.zera_coluna_pixel      = 1'b0;
    bus.zera_linha_quadrante   = 1'b0;
    bus.zera_coluna_quadrante  = 1'b0;
    bus.conta_linha_pixel      = 1'b0;
    bus.conta_coluna_pixel     = 1'b0;
    bus.conta_linha_quadrante  = 1'b0;
    bus.conta_coluna_quadrante = 1'b0;
    bus.pronto                 = 1'b0;
    case (state_q)
      INICIAL:       state_d = bus.iniciar ? PREPARA : INICIAL;
      PREPARA: begin
        bus.zera_linha_pixel      = 1'b1;
        bus.zera_coluna_pixel     = 1'b1;
        bus.zera_linha_quadrante  = 1'b1;
        bus.zera_coluna_quadrante = 1'b1;
        count_d                   = '0;
        state_d                   = ESPERA_FRAME;
      end
      ESPERA_FRAME:  state_d = bus.transmite_frame ? ESPERA_BYTE1 : ESPERA_FRAME;
      ESPERA_BYTE1:  state_d = byte_ok ? CAPTURA_BYTE1 : ESPERA_BYTE1;
      CAPTURA_BYTE1: begin
        bus.byte_estavel = 1'b1;
        state_d          = ESPERA_BYTE2;
      end
      ESPERA_BYTE2:  state_d = byte_ok ? CAPTURA_BYTE2 : ESPERA_BYTE2;
      CAPTURA_BYTE2: begin
        bus.byte_estavel = 1'b1;
        state_d          = AVALIA;
      end
      AVALIA:        state_d = bus.escreve_byte ? ARMAZENA : CONTA_PIXEL;
      ARMAZENA: begin
        bus.we_byte = 1'b1;
        count_d     = count_q == N ? count_q : count_q + 1'b1;
        state_d     = ATUALIZA_QUAD;
      end
      ATUALIZA_QUAD: begin
        bus.zera_coluna_quadrante  = bus.fim_coluna_quadrante;
        bus.conta_linha_quadrante  = bus.fim_coluna_quadrante;
        bus.conta_coluna_quadrante = !bus.fim_coluna_quadrante;
        state_d                    = count_q == N ? FIM : CONTA_PIXEL;
      end
      CONTA_PIXEL: begin
        bus.zera_coluna_pixel  = bus.fim_coluna_pixel;
        bus.conta_linha_pixel  = bus.fim_coluna_pixel;
        bus.conta_coluna_pixel = !bus.fim_coluna_pixel;
        state_d = bus.fim_coluna_pixel && bus.fim_linha_pixel ? FIM_ERRO : ESPERA_BYTE1;
      end
      FIM: begin
        bus.pronto = 1'b1;
        state_d    = INICIAL;
      end
      FIM_ERRO: begin
        bus.pronto = 1'b1;
        state_d    = INICIAL;
      end
      default:       state_d = INICIAL;
    endcase
    if (restart) state_d = PREPARA;
    erro_d = state_d == PREPARA ? 1'b0 : state_q == FIM_ERRO ? 1'b1 : erro_q;
  end
  assign bus.erro      = erro_q;
  assign bus.db_estado = state_q;
endmodule

// File: tb/tb_interface_ov7670_uc.sv
// tb_interface_ov7670_uc: directed checks of the capture control unit against a 4x4-pixel datapath model
module tb_interface_ov7670_uc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  interface_ov7670_uc_if bus ();
  interface_ov7670_uc dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [1:0] col, lin, qc, ql;
  logic [3:0] qaddr [64];
  int tests = 0, fails = 0;
  int n_be = 0, n_we = 0, n_ccp = 0;
  int be0, we0, we1, ccp0;
  assign bus.fim_coluna_pixel     = col == 2'd3;
  assign bus.fim_linha_pixel      = lin == 2'd3;
  assign bus.fim_coluna_quadrante = qc == 2'd2;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col <= '0;
      lin <= '0;
      qc  <= '0;
      ql  <= '0;
    end else begin
      col <= bus.zera_coluna_pixel ? 2'd0 : bus.conta_coluna_pixel ? col + 2'd1 : col;
      lin <= bus.zera_linha_pixel ? 2'd0 : bus.conta_linha_pixel ? lin + 2'd1 : lin;
      qc  <= bus.zera_coluna_quadrante ? 2'd0 : bus.conta_coluna_quadrante ? qc + 2'd1 : qc;
      ql  <= bus.zera_linha_quadrante ? 2'd0 : bus.conta_linha_quadrante ? ql + 2'd1 : ql;
    end
  always @(posedge clk) begin
    if (bus.byte_estavel) n_be <= n_be + 1;
    if (bus.conta_coluna_pixel) n_ccp <= n_ccp + 1;
    if (bus.we_byte) begin
      qaddr[n_we[5:0]] <= {ql, qc};
      n_we <= n_we + 1;
    end
  end
  function automatic logic [15:0] outs();
    return {5'd0, bus.byte_estavel, bus.we_byte, bus.zera_linha_pixel, bus.zera_coluna_pixel,
            bus.zera_linha_quadrante, bus.zera_coluna_quadrante, bus.conta_linha_pixel,
            bus.conta_coluna_pixel, bus.conta_linha_quadrante, bus.conta_coluna_quadrante, bus.pronto};
  endfunction
  function automatic logic [15:0] zeras();
    return {12'd0, bus.zera_linha_pixel, bus.zera_coluna_pixel, bus.zera_linha_quadrante, bus.zera_coluna_quadrante};
  endfunction
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_st(input string tag, input logic [3:0] s);
    int n = 0;
    while (bus.db_estado !== s && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 16'(bus.db_estado), 16'(s));
  endtask
  task automatic start();
    bus.iniciar = 1'b1;
    @(negedge clk);
    bus.iniciar = 1'b0;
    check("prepara_st", 16'(bus.db_estado), 16'h1);
    check("prepara_zera", zeras(), 16'hF);
    check("prepara_erro", 16'(bus.erro), 16'h0);
    @(negedge clk);
    check("espera_frame_st", 16'(bus.db_estado), 16'h2);
  endtask
  task automatic frame();
    bus.transmite_frame = 1'b1;
    @(negedge clk);
    bus.transmite_frame = 1'b0;
    check("frame_st", 16'(bus.db_estado), 16'h3);
  endtask
  task automatic pixel(input logic esc);
    wait_st("wait_byte1", 4'h3);
    bus.href = 1'b1;
    bus.transmite_byte = 1'b1;
    @(negedge clk);
    bus.transmite_byte = 1'b0;
    wait_st("wait_byte2", 4'h5);
    bus.transmite_byte = 1'b1;
    @(negedge clk);
    bus.transmite_byte = 1'b0;
    check("byte2_estavel", 16'(bus.byte_estavel), 16'h1);
    bus.escreve_byte = esc;
    repeat (2) @(negedge clk);
    check("we_byte", 16'(bus.we_byte), 16'(esc));
    bus.escreve_byte = 1'b0;
  endtask
  initial begin
    bus.iniciar = 1'b0;
    bus.href = 1'b0;
    bus.transmite_frame = 1'b0;
    bus.transmite_byte = 1'b0;
    bus.escreve_byte = 1'b0;
    repeat (2) @(negedge clk);
    // T1 reset state and start sequence
    check("rst_st", 16'(bus.db_estado), 16'h0);
    check("rst_outs", outs(), 16'h0);
    check("rst_erro", 16'(bus.erro), 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.iniciar = 1'b1;
    @(negedge clk);
    bus.iniciar = 1'b0;
    check("t1_prepara", 16'(bus.db_estado), 16'h1);
    @(negedge clk);
    check("t1_espera", 16'(bus.db_estado), 16'h2);
    bus.iniciar = 1'b1;
    @(negedge clk);
    bus.iniciar = 1'b0;
    check("t1_iniciar_ignored", 16'(bus.db_estado), 16'h2);
    // T2 one pixel, no store
    frame();
    be0 = n_be;
    we0 = n_we;
    ccp0 = n_ccp;
    pixel(1'b0);
    wait_st("t2_back", 4'h3);
    check("t2_be", 16'(n_be - be0), 16'd2);
    check("t2_we", 16'(n_we - we0), 16'd0);
    check("t2_ccp", 16'(n_ccp - ccp0), 16'd1);
    check("t2_col", 16'(col), 16'd1);
    // T3 nine stores complete the capture
    we0 = n_we;
    repeat (9) pixel(1'b1);
    @(negedge clk);
    check("t3_atualiza", 16'(bus.db_estado), 16'h9);
    @(negedge clk);
    check("t3_fim", 16'(bus.db_estado), 16'hB);
    check("t3_pronto", 16'(bus.pronto), 16'h1);
    @(negedge clk);
    check("t3_inicial", 16'(bus.db_estado), 16'h0);
    check("t3_pronto_drop", 16'(bus.pronto), 16'h0);
    check("t3_erro", 16'(bus.erro), 16'h0);
    check("t3_stores", 16'(n_we - we0), 16'd9);
    for (int k = 0; k < 9; k++)
      check($sformatf("t3_qaddr%0d", k), 16'(qaddr[we0 + k]), 16'((k / 3) * 4 + k % 3));
    // T4 byte pulses without HREF, then async reset mid-capture
    start();
    frame();
    be0 = n_be;
    bus.href = 1'b0;
    repeat (3) begin
      bus.transmite_byte = 1'b1;
      @(negedge clk);
      bus.transmite_byte = 1'b0;
      @(negedge clk);
    end
    check("t4_hold_st", 16'(bus.db_estado), 16'h3);
    check("t4_no_be", 16'(n_be - be0), 16'd0);
    bus.href = 1'b1;
    bus.transmite_byte = 1'b1;
    @(negedge clk);
    bus.transmite_byte = 1'b0;
    check("t4_resume_st", 16'(bus.db_estado), 16'h4);
    check("t4_resume_be", 16'(bus.byte_estavel), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_async_st", 16'(bus.db_estado), 16'h0);
    check("t4_async_outs", outs(), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // T5 frame restart after four stores (coinciding with a byte pulse)
    start();
    frame();
    we0 = n_we;
    repeat (4) pixel(1'b1);
    wait_st("t5_wait", 4'h3);
    bus.transmite_frame = 1'b1;
    bus.transmite_byte = 1'b1;
    @(negedge clk);
    bus.transmite_frame = 1'b0;
    bus.transmite_byte = 1'b0;
    check("t5_restart_st", 16'(bus.db_estado), 16'h1);
    check("t5_restart_zera", zeras(), 16'hF);
    @(negedge clk);
    check("t5_espera_frame", 16'(bus.db_estado), 16'h2);
    frame();
    we1 = n_we;
    repeat (9) pixel(1'b1);
    repeat (2) @(negedge clk);
    check("t5_pronto", 16'(bus.pronto), 16'h1);
    check("t5_stores", 16'(n_we - we0), 16'd13);
    check("t5_qaddr_first", 16'(qaddr[we1]), 16'h0);
    check("t5_qaddr_last", 16'(qaddr[we1 + 8]), 16'hA);
    @(negedge clk);
    // T6 frame ends after five stores
    start();
    frame();
    repeat (5) pixel(1'b1);
    repeat (11) pixel(1'b0);
    @(negedge clk);
    check("t6_fim_erro", 16'(bus.db_estado), 16'hC);
    check("t6_pronto", 16'(bus.pronto), 16'h1);
    @(negedge clk);
    check("t6_inicial", 16'(bus.db_estado), 16'h0);
    check("t6_erro", 16'(bus.erro), 16'h1);
    @(negedge clk);
    check("t6_erro_held", 16'(bus.erro), 16'h1);
    start();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
